// File: rtl/tea_ctr_byte_feeder.sv
// Byte-stream front end for tea_ctr: packs bytes into 64-bit blocks, issues one
// core operation per block with its own counter value, and serialises the result.
module tea_ctr_byte_feeder #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic [63:0] base_nonce,
    input  logic [7:0]  s_byte,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_last,
    output logic [7:0]  m_byte,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        core_start,
    output logic [63:0] core_data_in,
    output logic [63:0] core_nonce,
    input  logic [63:0] core_data_out,
    input  logic        core_done,
    output logic [31:0] blk_cnt,
    output logic        err_timeout
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {FILL, START, WAIT, DRAIN} state_t;

    state_t        state;
    logic [2:0]    cnt;
    logic [3:0]    n_bytes;
    logic          last_flag;
    logic [63:0]   nonce_base;
    logic [63:0]   blk_idx;
    logic [63:0]   unpack;
    logic [2:0]    rem;
    logic [TW-1:0] tmo;
    logic [2:0]    wr_pos;
    logic          hs;

    // core_data_in doubles as the pack register; byte 0 lands in the top byte
    assign wr_pos = ~cnt;
    assign hs     = s_valid & s_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FILL;
            cnt          <= '0;
            n_bytes      <= '0;
            last_flag    <= 1'b0;
            nonce_base   <= '0;
            blk_idx      <= '0;
            unpack       <= '0;
            rem          <= '0;
            tmo          <= '0;
            s_ready      <= 1'b1;
            m_byte       <= '0;
            m_valid      <= 1'b0;
            m_last       <= 1'b0;
            core_start   <= 1'b0;
            core_data_in <= '0;
            core_nonce   <= '0;
            blk_cnt      <= '0;
            err_timeout  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (hs) begin
                        core_data_in[{wr_pos, 3'b000} +: 8] <= s_byte;
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7 || s_last) begin
                            n_bytes    <= {1'b0, cnt} + 4'd1;
                            last_flag  <= s_last;
                            core_nonce <= nonce_base + blk_idx;
                            core_start <= 1'b1;
                            s_ready    <= 1'b0;
                            state      <= START;
                        end
                    end else if (init && cnt == 3'd0) begin
                        nonce_base  <= base_nonce;
                        blk_idx     <= '0;
                        blk_cnt     <= '0;
                        err_timeout <= 1'b0;
                    end
                end
                START: begin
                    core_start <= 1'b0;
                    tmo        <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // tmo == 0 is the first WAIT cycle, where core_done may be stale
                    if (tmo != '0 && core_done) begin
                        unpack  <= {core_data_out[55:0], 8'h00};
                        m_byte  <= core_data_out[63:56];
                        m_valid <= 1'b1;
                        m_last  <= last_flag && (n_bytes == 4'd1);
                        rem     <= 3'(n_bytes - 4'd1);
                        blk_idx <= blk_idx + 64'd1;
                        blk_cnt <= blk_cnt + 32'd1;
                        state   <= DRAIN;
                    end else if (tmo == TW'(TIMEOUT - 1)) begin
                        err_timeout  <= 1'b1;
                        cnt          <= '0;
                        core_data_in <= '0;
                        s_ready      <= 1'b1;
                        state        <= FILL;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        if (rem == 3'd0) begin
                            m_valid      <= 1'b0;
                            m_last       <= 1'b0;
                            m_byte       <= '0;
                            cnt          <= '0;
                            core_data_in <= '0;
                            s_ready      <= 1'b1;
                            state        <= FILL;
                        end else begin
                            m_byte <= unpack[63:56];
                            unpack <= {unpack[55:0], 8'h00};
                            rem    <= rem - 3'd1;
                            m_last <= last_flag && (rem == 3'd1);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: doc/tea_ctr_byte_feeder.md
# tea_ctr_byte_feeder

Byte-stream front end for the `tea_ctr` core. Packs an 8-bit input stream into 64-bit blocks and gives each block its own counter value. Drives one `tea_ctr` operation per block, then serialises the 64-bit result back to a byte stream. Sits directly upstream and downstream of `tea_ctr`: it owns the core's `start`, `data_in` and `nonce` inputs and consumes its `data_out` and `done` outputs.

## Interface
- `TIMEOUT`, 1024: maximum cycles to wait for `core_done` after `core_start` before flagging an error.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `init` in 1: one-cycle pulse; loads `base_nonce` and clears the block counter. Accepted only in FILL with zero bytes buffered; ignored otherwise.
- `base_nonce` in 64: starting counter-block value.
- `s_byte` in 8: input byte.
- `s_valid` in 1: input byte valid.
- `s_ready` out 1: feeder can accept a byte.
- `s_last` in 1: marks the final byte of a message.
- `m_byte` out 8: output byte.
- `m_valid` out 1: output byte valid.
- `m_ready` in 1: downstream accepts a byte.
- `m_last` out 1: final output byte of a message.
- `core_start` out 1: one-cycle start pulse to `tea_ctr`.
- `core_data_in` out 64: packed block to `tea_ctr`.
- `core_nonce` out 64: per-block counter value to `tea_ctr`.
- `core_data_out` in 64: `tea_ctr` result.
- `core_done` in 1: `tea_ctr` completion.
- `blk_cnt` out 32: blocks completed since reset or `init`.
- `err_timeout` out 1: sticky timeout flag; cleared by `rst` or `init`.

## Operation
- States: FILL, START, WAIT, DRAIN.
- **FILL**
  - `s_ready`=1.
  - Each handshake (`s_valid`&`s_ready`) writes the byte into the pack register, big-endian: byte 0 goes to [63:56], byte 7 to [7:0].
  - The byte count increments on each handshake.
  - On the 8th byte, or on a byte with `s_last`=1, go to START.
  - A partial block is zero-padded in the low bytes.
  - The byte count n (1..8) and the last flag are latched.
- **START**
  - `core_start`=1 for exactly one cycle.
  - `core_data_in` = pack register; `core_nonce` = `base_nonce` + block index, 64-bit wrap-around.
  - Both are held stable from START until leaving WAIT.
  - Go to WAIT.
- **WAIT**
  - `core_done` is ignored in the first cycle after START, so a stale level from the previous operation is not taken as completion.
  - From the second cycle on, `core_done`=1 latches `core_data_out` into the unpack register.
  - On that capture: block index += 1, `blk_cnt` += 1, go to DRAIN.
  - The timeout counter runs in WAIT. When it reaches `TIMEOUT`, set `err_timeout`, drop the block (no output, index not incremented), clear the buffer and return to FILL.
- **DRAIN**
  - Presents n bytes MSB-first.
  - `m_valid`=1, `m_byte` = current byte; advances on `m_ready`.
  - `m_last`=1 on byte n only if the latched last flag is set.
  - After byte n, return to FILL with count 0.
  - `s_ready`=0 throughout START, WAIT and DRAIN.
- `s_last` does not reset the block index; consecutive messages continue counting until `init`.
- `blk_cnt` wraps at 2^32.

## Timing
- Reset values:
  - `s_ready`=1, `m_valid`=0, `m_last`=0, `m_byte`=0.
  - `core_start`=0, `core_data_in`=0, `core_nonce`=0.
  - `blk_cnt`=0, `err_timeout`=0.
  - Internal: nonce base 0, block index 0, state FILL.
- The last byte accepted in cycle t produces `core_start` high in cycle t+1.
- `core_done` seen in cycle d gives first `m_valid` in cycle d+1.
- Byte throughput is 1 per cycle in both FILL and DRAIN, excluding core latency.
- `m_byte` and `m_last` are held while `m_valid`=1 and `m_ready`=0.
- `init` arriving together with a byte handshake: the byte is accepted and `init` is ignored.
- `rst` mid-operation returns to FILL immediately. Any in-flight block is discarded and `core_start` drops in the same cycle (asynchronous).
- `core_done`=1 in the same cycle the timeout count reaches `TIMEOUT`: `core_done` wins and no error is flagged.

## Test plan
- **Full block.** `init` with `base_nonce`=64'h1234567890ABCDEF, then bytes 48 65 6C 6C 6F 20 54 45 (last on 8th).
  - `core_data_in`=64'h48656C6C6F205445, `core_nonce`=64'h1234567890ABCDEF, one `core_start` pulse.
  - Model returns 64'h0011223344556677: output 00 11 22 33 44 55 66 77, `m_last` on 77, `blk_cnt`=1.
- **Partial block.** Bytes AA BB CC, `s_last` on CC.
  - `core_data_in`=64'hAABBCC0000000000.
  - Exactly 3 output bytes, `m_last` on the 3rd.
- **Counter wrap.** `base_nonce`=64'hFFFFFFFFFFFFFFFF, 16 bytes.
  - Block 0 `core_nonce`=FFFF_FFFF_FFFF_FFFF; block 1 `core_nonce`=0.
- **Backpressure / stale done.**
  - `m_ready` toggling 1010: every byte appears once, in order, held stable while stalled.
  - `core_done` held high from the previous block: WAIT does not exit in the first cycle after START.
- **Timeout.** `TIMEOUT`=16, core never asserts `core_done`.
  - `err_timeout`=1 after 16 WAIT cycles, no output bytes, `blk_cnt` unchanged, `s_ready`=1.
- **Reset mid-WAIT.** Assert `rst` 3 cycles into WAIT.
  - All outputs return to reset values asynchronously; the next message starts at block index 0.
